// File: rtl/dram_cmd_sequencer_pkg.sv
// Shared types for the DRAM command sequencer: address widths, command encodings, FSM states.
// ST_CLOSE exists only when DRAM_SEQ_CLOSE_PAGE_EN is defined (closed-page policy).
package dram_cmd_sequencer_pkg;

  localparam int BANK_GROUP_WIDTH = 2;
  localparam int BANK_WIDTH       = 2;
  localparam int ROW_WIDTH        = 16;
  localparam int COL_WIDTH        = 10;
  localparam int BANK_ID_WIDTH    = BANK_GROUP_WIDTH + BANK_WIDTH;
  localparam int NUM_BANKS        = 1 << BANK_ID_WIDTH;
  localparam int CNT_WIDTH        = 4;

  localparam logic [2:0] CMD_NOP = 3'd0;
  localparam logic [2:0] CMD_ACT = 3'd1;
  localparam logic [2:0] CMD_PRE = 3'd2;
  localparam logic [2:0] CMD_RD  = 3'd3;
  localparam logic [2:0] CMD_WR  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DECIDE   = 3'd1,
    ST_PRE      = 3'd2,
    ST_WAIT_RP  = 3'd3,
    ST_ACT      = 3'd4,
    ST_WAIT_RCD = 3'd5,
    ST_RW       = 3'd6
`ifdef DRAM_SEQ_CLOSE_PAGE_EN
    ,ST_CLOSE   = 3'd7
`endif
  } state_t;

  function automatic logic [BANK_ID_WIDTH-1:0] bank_id(
    input logic [BANK_GROUP_WIDTH-1:0] bg,
    input logic [BANK_WIDTH-1:0]       b
  );
    return {bg, b};
  endfunction

endpackage

// File: rtl/bank_state_tracker.sv
// Per-bank open/precharged flag plus open row; updates are registered, the query is combinational.
module bank_state_tracker
  import dram_cmd_sequencer_pkg::*;
(
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_clear,
  input  logic                        i_upd_precharge,
  input  logic                        i_upd_activate,
  input  logic [BANK_GROUP_WIDTH-1:0] i_upd_bank_group,
  input  logic [BANK_WIDTH-1:0]       i_upd_bank,
  input  logic [ROW_WIDTH-1:0]        i_upd_row,
  input  logic [BANK_GROUP_WIDTH-1:0] i_qry_bank_group,
  input  logic [BANK_WIDTH-1:0]       i_qry_bank,
  output logic                        o_qry_open,
  output logic [ROW_WIDTH-1:0]        o_qry_row
);

  logic [NUM_BANKS-1:0]     r_open;
  logic [ROW_WIDTH-1:0]     r_row [NUM_BANKS];
  logic [BANK_ID_WIDTH-1:0] w_upd_id;
  logic [BANK_ID_WIDTH-1:0] w_qry_id;

  assign w_upd_id = bank_id(i_upd_bank_group, i_upd_bank);
  assign w_qry_id = bank_id(i_qry_bank_group, i_qry_bank);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)               r_open           <= '0;
    else if (i_clear)           r_open           <= '0;
    else if (i_upd_precharge)   r_open[w_upd_id] <= 1'b0;
    else if (i_upd_activate)    r_open[w_upd_id] <= 1'b1;
  end

  // Row storage is only meaningful while the open flag is set, so it carries no reset.
  always_ff @(posedge i_clk) begin
    if (i_upd_activate) r_row[w_upd_id] <= i_upd_row;
  end

  assign o_qry_open = r_open[w_qry_id];
  assign o_qry_row  = r_row[w_qry_id];

endmodule

// File: rtl/dram_cmd_sequencer.sv
// Per-request PRE/ACT/RD/WR sequencer enforcing tRP and tRCD against a bank state tracker.
// Define DRAM_SEQ_CLOSE_PAGE_EN for closed-page policy (PRE issued after every RD/WR).
module dram_cmd_sequencer
  import dram_cmd_sequencer_pkg::*;
#(
  parameter int T_RP  = 3,
  parameter int T_RCD = 4
)(
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_clear,
  input  logic                        i_req_valid,
  output logic                        o_req_ready,
  input  logic                        i_req_write,
  input  logic [BANK_GROUP_WIDTH-1:0] i_req_bank_group,
  input  logic [BANK_WIDTH-1:0]       i_req_bank,
  input  logic [ROW_WIDTH-1:0]        i_req_row,
  input  logic [COL_WIDTH-1:0]        i_req_col,
  output logic                        o_cmd_valid,
  input  logic                        i_cmd_ready,
  output logic [2:0]                  o_cmd_type,
  output logic [BANK_GROUP_WIDTH-1:0] o_cmd_bank_group,
  output logic [BANK_WIDTH-1:0]       o_cmd_bank,
  output logic [ROW_WIDTH-1:0]        o_cmd_row,
  output logic [COL_WIDTH-1:0]        o_cmd_col,
  output logic                        o_busy,
  output logic                        o_stat_hit,
  output logic                        o_stat_miss,
  output logic                        o_stat_conflict
);

  localparam logic [CNT_WIDTH-1:0] RP_LOAD  = CNT_WIDTH'(T_RP - 1);
  localparam logic [CNT_WIDTH-1:0] RCD_LOAD = CNT_WIDTH'(T_RCD - 1);

  state_t                      r_state;
  state_t                      w_next;
  logic                        r_write;
  logic [BANK_GROUP_WIDTH-1:0] r_bg;
  logic [BANK_WIDTH-1:0]       r_bank;
  logic [ROW_WIDTH-1:0]        r_row;
  logic [COL_WIDTH-1:0]        r_col;
  logic [CNT_WIDTH-1:0]        r_cnt;

  logic                        w_req_ready;
  logic                        w_accept;
  logic                        w_clear_pulse;
  logic                        w_qry_open;
  logic [ROW_WIDTH-1:0]        w_qry_row;
  logic                        w_hit;
  logic                        w_upd_pre;
  logic                        w_upd_act;
  logic                        w_wait_done;

  assign w_req_ready   = (r_state == ST_IDLE) && !i_clear;
  assign w_clear_pulse = (r_state == ST_IDLE) && i_clear;
  assign w_accept      = i_req_valid && w_req_ready;
  assign w_hit         = w_qry_open && (w_qry_row == r_row);
  assign w_wait_done   = (r_cnt <= CNT_WIDTH'(1));

  bank_state_tracker u_bank_state_tracker (
    .i_clk            (i_clk),
    .i_rst_n          (~i_rst),
    .i_clear          (w_clear_pulse),
    .i_upd_precharge  (w_upd_pre),
    .i_upd_activate   (w_upd_act),
    .i_upd_bank_group (r_bg),
    .i_upd_bank       (r_bank),
    .i_upd_row        (r_row),
    .i_qry_bank_group (r_bg),
    .i_qry_bank       (r_bank),
    .o_qry_open       (w_qry_open),
    .o_qry_row        (w_qry_row)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:     if (w_accept) w_next = ST_DECIDE;
      ST_DECIDE: begin
        if (!w_qry_open) w_next = ST_ACT;
        else if (w_hit)  w_next = ST_RW;
        else             w_next = ST_PRE;
      end
      ST_PRE:      if (i_cmd_ready) w_next = (T_RP == 1) ? ST_ACT : ST_WAIT_RP;
      ST_WAIT_RP:  if (w_wait_done) w_next = ST_ACT;
      ST_ACT:      if (i_cmd_ready) w_next = (T_RCD == 1) ? ST_RW : ST_WAIT_RCD;
      ST_WAIT_RCD: if (w_wait_done) w_next = ST_RW;
`ifdef DRAM_SEQ_CLOSE_PAGE_EN
      ST_RW:       if (i_cmd_ready) w_next = ST_CLOSE;
      ST_CLOSE:    if (i_cmd_ready) w_next = ST_IDLE;
`else
      ST_RW:       if (i_cmd_ready) w_next = ST_IDLE;
`endif
      default:     w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_cmd_valid     = 1'b0;
    o_cmd_type      = CMD_NOP;
    o_stat_hit      = 1'b0;
    o_stat_miss     = 1'b0;
    o_stat_conflict = 1'b0;
    w_upd_pre       = 1'b0;
    w_upd_act       = 1'b0;
    case (r_state)
      ST_DECIDE: begin
        o_stat_hit      = w_hit;
        o_stat_miss     = !w_qry_open;
        o_stat_conflict = w_qry_open && !w_hit;
      end
      ST_PRE: begin
        o_cmd_valid = 1'b1;
        o_cmd_type  = CMD_PRE;
        w_upd_pre   = i_cmd_ready;
      end
      ST_ACT: begin
        o_cmd_valid = 1'b1;
        o_cmd_type  = CMD_ACT;
        w_upd_act   = i_cmd_ready;
      end
      ST_RW: begin
        o_cmd_valid = 1'b1;
        o_cmd_type  = r_write ? CMD_WR : CMD_RD;
      end
`ifdef DRAM_SEQ_CLOSE_PAGE_EN
      ST_CLOSE: begin
        o_cmd_valid = 1'b1;
        o_cmd_type  = CMD_PRE;
        w_upd_pre   = i_cmd_ready;
      end
`endif
      default: ;
    endcase
  end

  // Counters load on the handshake edge so back-pressure never shortens tRP/tRCD.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (r_state == ST_PRE && i_cmd_ready) begin
      r_cnt <= RP_LOAD;
    end else if (r_state == ST_ACT && i_cmd_ready) begin
      r_cnt <= RCD_LOAD;
    end else if ((r_state == ST_WAIT_RP || r_state == ST_WAIT_RCD) && r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_write <= 1'b0;
      r_bg    <= '0;
      r_bank  <= '0;
      r_row   <= '0;
      r_col   <= '0;
    end else if (w_accept) begin
      r_write <= i_req_write;
      r_bg    <= i_req_bank_group;
      r_bank  <= i_req_bank;
      r_row   <= i_req_row;
      r_col   <= i_req_col;
    end
  end

  assign o_req_ready      = w_req_ready;
  assign o_busy           = (r_state != ST_IDLE);
  assign o_cmd_bank_group = r_bg;
  assign o_cmd_bank       = r_bank;
  assign o_cmd_row        = r_row;
  assign o_cmd_col        = r_col;

endmodule

// File: tb/tb_dram_cmd_sequencer.sv
// Bench for dram_cmd_sequencer: directed vector table, clear/reset corner sequences, randomized traffic.
// Expected command traces come from a per-bank open-row model and the tRP/tRCD gap rules.
module tb_dram_cmd_sequencer;

  localparam int T_RP  = 3;
  localparam int T_RCD = 4;
  localparam logic [2:0] C_NOP = 3'd0, C_ACT = 3'd1, C_PRE = 3'd2, C_RD = 3'd3, C_WR = 3'd4;
  localparam int K_HIT = 0, K_MISS = 1, K_CONF = 2;
`ifdef DRAM_SEQ_CLOSE_PAGE_EN
  localparam bit CLOSE_PAGE = 1'b1;
`else
  localparam bit CLOSE_PAGE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, clear, req_valid, req_write, cmd_ready;
  logic [1:0]  req_bg, req_bank;
  logic [15:0] req_row;
  logic [9:0]  req_col;
  logic        req_ready, cmd_valid, busy, stat_hit, stat_miss, stat_conflict;
  logic [2:0]  cmd_type;
  logic [1:0]  cmd_bg, cmd_bank;
  logic [15:0] cmd_row;
  logic [9:0]  cmd_col;

  always #5 clk = ~clk;

  dram_cmd_sequencer #(.T_RP(T_RP), .T_RCD(T_RCD)) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_clear          (clear),
    .i_req_valid      (req_valid),
    .o_req_ready      (req_ready),
    .i_req_write      (req_write),
    .i_req_bank_group (req_bg),
    .i_req_bank       (req_bank),
    .i_req_row        (req_row),
    .i_req_col        (req_col),
    .o_cmd_valid      (cmd_valid),
    .i_cmd_ready      (cmd_ready),
    .o_cmd_type       (cmd_type),
    .o_cmd_bank_group (cmd_bg),
    .o_cmd_bank       (cmd_bank),
    .o_cmd_row        (cmd_row),
    .o_cmd_col        (cmd_col),
    .o_busy           (busy),
    .o_stat_hit       (stat_hit),
    .o_stat_miss      (stat_miss),
    .o_stat_conflict  (stat_conflict)
  );

  typedef struct {
    logic        w;
    logic [1:0]  bg;
    logic [1:0]  b;
    logic [15:0] row;
    logic [9:0]  col;
    int          kind;
    int          bp;
    int          inject;
    bit          pre_clear;
  } vec_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  bit          m_open [16];
  logic [15:0] m_row  [16];
  vec_t        tbl    [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_kind(input int bank, input logic [15:0] row);
    if (!m_open[bank])          return K_MISS;
    else if (m_row[bank] == row) return K_HIT;
    else                         return K_CONF;
  endfunction

  function automatic logic [2:0] stat_of(input int kind);
    return (kind == K_HIT) ? 3'b100 : (kind == K_MISS) ? 3'b010 : 3'b001;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_open[i] = 1'b0;
  endtask

  // Pulse rst in the current cycle, check the asynchronous drop, then release.
  task automatic rst_abort();
    clear = 1'b0;
    rst   = 1'b1;
    #1;
    chk("rst_async_cmd_valid", cmd_valid, 1'b0);
    chk("rst_async_busy", busy, 1'b0);
    chk("rst_async_cmd_type", cmd_type, C_NOP);
    chk("rst_async_cmd_row", cmd_row, 16'h0);
    tick();
    rst = 1'b0;
    model_reset();
    #1;
    chk("post_rst_req_ready", req_ready, 1'b1);
    tick();
  endtask

  task automatic do_clear();
    clear     = 1'b1;
    req_valid = 1'b1;
    #1;
    chk("clear_req_ready_low", req_ready, 1'b0);
    tick();
    clear     = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("clear_no_accept_busy", busy, 1'b0);
    tick();
    model_reset();
  endtask

  // inject: 0 none, 1 clear during WAIT_RCD, 2 rst during WAIT_RCD, 3 rst while RD/WR held
  task automatic do_req(input logic w, input logic [1:0] bg, input logic [1:0] b,
                        input logic [15:0] row, input logic [9:0] col,
                        input int kind_in, input int bp_in, input int inject);
    int         bank, kind, guard, gap, bp;
    logic [2:0] seq[$];
    logic [2:0] prev;
    bank = int'({bg, b});
    kind = (kind_in < 0 || CLOSE_PAGE) ? model_kind(bank, row) : kind_in;
    if (kind == K_CONF) seq.push_back(C_PRE);
    if (kind != K_HIT)  seq.push_back(C_ACT);
    seq.push_back(w ? C_WR : C_RD);
    if (CLOSE_PAGE)     seq.push_back(C_PRE);

    req_valid = 1'b1; req_write = w; req_bg = bg; req_bank = b; req_row = row; req_col = col;
    clear = 1'b0; cmd_ready = 1'($urandom_range(0, 1));
    #1;
    guard = 0;
    while (req_ready !== 1'b1) begin
      if (guard == 20) begin
        chk("req_ready_wait", req_ready, 1'b1);
        break;
      end
      tick(); #1; guard++;
    end
    tick();
    req_valid = 1'b0;
    req_row   = 16'($urandom);
    req_col   = 10'($urandom);
    prev = C_NOP;
    for (int i = 0; i < seq.size(); i++) begin
      gap = (i == 0) ? 2 : (prev == C_PRE) ? T_RP : (prev == C_ACT) ? T_RCD : 1;
      for (int k = 1; k < gap; k++) begin
        cmd_ready = 1'($urandom_range(0, 1));
        clear     = (inject == 1 && prev == C_ACT);
        if (inject == 2 && prev == C_ACT && k == 1) begin
          rst_abort();
          return;
        end
        #1;
        chk("gap_cmd_valid", cmd_valid, 1'b0);
        chk("stat_pulses", {stat_hit, stat_miss, stat_conflict},
            (i == 0 && k == 1) ? stat_of(kind) : 3'b000);
        chk("gap_busy", busy, 1'b1);
        tick();
      end
      clear = 1'b0;
      bp = (bp_in < 0) ? int'($urandom_range(0, 2)) : bp_in;
      for (int s = 0; s <= bp; s++) begin
        cmd_ready = (s == bp);
        if (inject == 3 && (seq[i] == C_RD || seq[i] == C_WR) && s == 0) begin
          rst_abort();
          return;
        end
        #1;
        chk("cmd_valid", cmd_valid, 1'b1);
        chk("cmd_type", cmd_type, seq[i]);
        chk("cmd_bank_group", cmd_bg, bg);
        chk("cmd_bank", cmd_bank, b);
        if (seq[i] == C_ACT) chk("cmd_row", cmd_row, row);
        if (seq[i] == C_RD || seq[i] == C_WR) chk("cmd_col", cmd_col, col);
        tick();
      end
      prev = seq[i];
    end
    #1;
    chk("done_req_ready", req_ready, 1'b1);
    chk("done_busy", busy, 1'b0);
    chk("done_cmd_valid", cmd_valid, 1'b0);
    if (CLOSE_PAGE) m_open[bank] = 1'b0;
    else begin
      m_open[bank] = 1'b1;
      m_row[bank]  = row;
    end
    tick();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b0, 2'd0, 2'd1, 16'h0010, 10'h008, K_MISS, 0, 0, 1'b0};
    tbl[1]  = '{1'b0, 2'd0, 2'd1, 16'h0010, 10'h009, K_HIT,  0, 0, 1'b0};
    tbl[2]  = '{1'b1, 2'd0, 2'd1, 16'h0020, 10'h003, K_CONF, 0, 0, 1'b0};
    tbl[3]  = '{1'b0, 2'd2, 2'd3, 16'h0033, 10'h001, K_MISS, 5, 0, 1'b0};
    tbl[4]  = '{1'b0, 2'd1, 2'd0, 16'h0005, 10'h002, K_MISS, 0, 0, 1'b0};
    tbl[5]  = '{1'b0, 2'd1, 2'd0, 16'h0005, 10'h002, K_MISS, 1, 0, 1'b1};
    tbl[6]  = '{1'b0, 2'd3, 2'd2, 16'h0007, 10'h004, K_MISS, 0, 1, 1'b0};
    tbl[7]  = '{1'b1, 2'd3, 2'd2, 16'h0007, 10'h005, K_HIT,  0, 0, 1'b0};
    tbl[8]  = '{1'b0, 2'd0, 2'd0, 16'h0044, 10'h006, K_MISS, 0, 2, 1'b0};
    tbl[9]  = '{1'b0, 2'd0, 2'd0, 16'h0044, 10'h006, K_MISS, 0, 0, 1'b0};
    tbl[10] = '{1'b1, 2'd2, 2'd3, 16'h0033, 10'h007, K_MISS, 2, 3, 1'b0};
    tbl[11] = '{1'b0, 2'd2, 2'd3, 16'h0033, 10'h007, K_MISS, 0, 0, 1'b0};
    tbl[12] = '{1'b0, 2'd0, 2'd1, 16'h0020, 10'h008, K_MISS, 0, 0, 1'b0};
    tbl[13] = '{1'b0, 2'd0, 2'd1, 16'h0020, 10'h009, K_HIT,  1, 0, 1'b0};
    tbl[14] = '{1'b0, 2'd0, 2'd1, 16'h0021, 10'h00A, K_CONF, 1, 0, 1'b0};

    rst = 1'b1; clear = 1'b0; req_valid = 1'b0; req_write = 1'b0; cmd_ready = 1'b0;
    req_bg = '0; req_bank = '0; req_row = '0; req_col = '0;
    model_reset();
    tick(); tick();
    #1;
    chk("reset_req_ready", req_ready, 1'b1);
    chk("reset_cmd_valid", cmd_valid, 1'b0);
    chk("reset_cmd_type", cmd_type, C_NOP);
    chk("reset_cmd_addr", {cmd_bg, cmd_bank, cmd_row, cmd_col}, 30'h0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_stats", {stat_hit, stat_miss, stat_conflict}, 3'b000);
    tick();
    rst = 1'b0;
    tick();

    for (int v = 0; v < 15; v++) begin
      if (tbl[v].pre_clear) do_clear();
      do_req(tbl[v].w, tbl[v].bg, tbl[v].b, tbl[v].row, tbl[v].col,
             tbl[v].kind, tbl[v].bp, tbl[v].inject);
    end

    for (int r = 0; r < 60; r++) begin
      int          sel;
      logic [1:0]  bg, b;
      sel = int'($urandom_range(0, 3));
      bg  = (sel == 0) ? 2'd0 : (sel == 1) ? 2'd1 : (sel == 2) ? 2'd2 : 2'd3;
      b   = (sel == 0) ? 2'd0 : (sel == 1) ? 2'd3 : (sel == 2) ? 2'd1 : 2'd2;
      if ($urandom_range(0, 9) == 0) do_clear();
      do_req(1'($urandom_range(0, 1)), bg, b, 16'h0100 + 16'($urandom_range(0, 2)),
             10'($urandom), -1, -1, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
